// File: rtl/tile_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tile_rom_arbiter
// Purpose  : Shares the tile-graphics ROM port between video tile fetches
//            (priority) and CPU ROM readback, with an aging counter that
//            forces a starved CPU request ahead of video.
// Options  : TILE_ARB_LASTADDR_CACHE_EN - one-entry last-video-address tag.
// Revision : 1.0 - initial release
// ============================================================================
module tile_rom_arbiter #(
    parameter int AW           = 18,
    parameter int DW           = 32,
    parameter int CPU_MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          vid_overrun,
    input  logic          ovr_clr,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_data,
    output logic          cpu_ack,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_dout
);

    localparam int             WCW        = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WCW-1:0] C_WAIT_MAX = WCW'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VID  = 2'd1,
        S_CPU  = 2'd2
    } state_t;

    state_t         state_q;
    logic [AW-1:0]  vid_addr_q;
    logic           vid_pend_q;
    logic           vid_pend_d;
    logic           vid_overrun_q;
    logic           vid_overrun_d;
    logic [WCW-1:0] wait_cnt_q;
    logic [WCW-1:0] wait_cnt_d;
    logic           mem_req_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  vid_data_q;
    logic           vid_valid_q;
    logic [DW-1:0]  cpu_data_q;
    logic           cpu_ack_q;

    logic           w_vid_hit;
    logic           w_vid_new;
    logic           w_vid_any;
    logic           w_cpu_go;
    logic           w_vid_go;
    logic [AW-1:0]  w_vid_grant_addr;

`ifdef TILE_ARB_LASTADDR_CACHE_EN
    logic [AW-1:0]  tag_q;
    logic           tag_vld_q;

    assign w_vid_hit = vid_req & tag_vld_q & (vid_addr == tag_q);

    // Only completed video fetches refresh the tag; CPU reads never do.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else if ((state_q == S_VID) && mem_ack) begin
            tag_q     <= mem_addr_q;
            tag_vld_q <= 1'b1;
        end
    end
`else
    assign w_vid_hit = 1'b0;
`endif

    always_comb begin
        // A fresh vid_req counts as pending this cycle so an idle port
        // issues it on the very next edge.
        w_vid_new        = vid_req & ~w_vid_hit;
        w_vid_any        = vid_pend_q | w_vid_new;
        w_cpu_go         = (state_q == S_IDLE) & cpu_req & ~cpu_ack_q &
                           ((wait_cnt_q >= C_WAIT_MAX) | ~w_vid_any);
        w_vid_go         = (state_q == S_IDLE) & ~w_cpu_go & w_vid_any;
        w_vid_grant_addr = vid_pend_q ? vid_addr_q : vid_addr;

        vid_pend_d = vid_pend_q;
        if (w_vid_new) begin
            vid_pend_d = ~(w_vid_go & ~vid_pend_q);
        end else if (w_vid_go) begin
            vid_pend_d = 1'b0;
        end

        // Set has priority over clear.
        vid_overrun_d = vid_overrun_q;
        if (ovr_clr) begin
            vid_overrun_d = 1'b0;
        end
        if (w_vid_new & vid_pend_q & ~w_vid_go) begin
            vid_overrun_d = 1'b1;
        end

        wait_cnt_d = wait_cnt_q;
        if (w_cpu_go | ~cpu_req) begin
            wait_cnt_d = '0;
        end else if ((state_q != S_CPU) & ~cpu_ack_q & (wait_cnt_q < C_WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vid_addr_q    <= '0;
            vid_pend_q    <= 1'b0;
            vid_overrun_q <= 1'b0;
            wait_cnt_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            vid_data_q    <= '0;
            vid_valid_q   <= 1'b0;
            cpu_data_q    <= '0;
            cpu_ack_q     <= 1'b0;
        end else begin
            vid_pend_q    <= vid_pend_d;
            vid_overrun_q <= vid_overrun_d;
            wait_cnt_q    <= wait_cnt_d;
            if (w_vid_new) begin
                vid_addr_q <= vid_addr;
            end
            vid_valid_q <= w_vid_hit;
            cpu_ack_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (w_cpu_go) begin
                        state_q    <= S_CPU;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= cpu_addr;
                    end else if (w_vid_go) begin
                        state_q    <= S_VID;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= w_vid_grant_addr;
                    end
                end
                S_VID: begin
                    if (mem_ack) begin
                        state_q     <= S_IDLE;
                        mem_req_q   <= 1'b0;
                        vid_data_q  <= mem_dout;
                        vid_valid_q <= 1'b1;
                    end
                end
                S_CPU: begin
                    if (mem_ack) begin
                        state_q    <= S_IDLE;
                        mem_req_q  <= 1'b0;
                        cpu_data_q <= mem_dout;
                        cpu_ack_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign vid_data    = vid_data_q;
    assign vid_valid   = vid_valid_q;
    assign vid_overrun = vid_overrun_q;
    assign cpu_data    = cpu_data_q;
    assign cpu_ack     = cpu_ack_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_rom_arbiter
// Purpose  : Directed self-checking bench for tile_rom_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vid_req = 1'b0;
    logic [17:0] vid_addr = '0;
    logic [31:0] vid_data;
    logic        vid_valid;
    logic        vid_overrun;
    logic        ovr_clr = 1'b0;
    logic        cpu_req = 1'b0;
    logic [17:0] cpu_addr = '0;
    logic [31:0] cpu_data;
    logic        cpu_ack;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_dout = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic        mem_auto = 1'b1;
    int          mem_lat  = 3;
    logic        rsp_busy = 1'b0;
    int          rsp_cnt  = 0;

    logic [17:0] txq[$];
    int          nvv = 0;
    int          nack = 0;
    int          addr_chg = 0;
    logic        mreq_prev = 1'b0;
    logic [17:0] maddr_prev = '0;

    tile_rom_arbiter #(.AW(18), .DW(32), .CPU_MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_overrun(vid_overrun), .ovr_clr(ovr_clr),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] resp_data(input logic [17:0] a);
        if (a == 18'h01234) return 32'hDEADBEEF;
        if (a == 18'h3FFFF) return 32'h12345678;
        return {14'h2A5, a} ^ 32'h5A5A0000;
    endfunction

    // Memory model: acks mem_lat cycles after mem_req rises.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!mem_auto) begin
                rsp_busy = 1'b0;
            end else if (mem_ack) begin
                mem_ack  = 1'b0;
                rsp_busy = 1'b0;
            end else if (rsp_busy) begin
                rsp_cnt++;
                if (rsp_cnt == mem_lat) begin
                    mem_ack  = 1'b1;
                    mem_dout = resp_data(mem_addr);
                end
            end else if (mem_req) begin
                rsp_busy = 1'b1;
                rsp_cnt  = 0;
            end
        end
    end

    // Transaction log and pulse counters.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !mreq_prev) txq.push_back(mem_addr);
            if (mem_req && mreq_prev && (mem_addr != maddr_prev)) addr_chg++;
            mreq_prev  = mem_req;
            maddr_prev = mem_addr;
            if (vid_valid) nvv++;
            if (cpu_ack) nack++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_vid(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (vid_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_cpu(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (cpu_ack) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({mem_req, vid_valid, vid_overrun, cpu_ack} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {mem_req, vid_valid, vid_overrun, cpu_ack});
        end
        n_checks++;
        if (vid_data !== 32'h0 || cpu_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got vid %h cpu %h want 0", vid_data, cpu_data);
        end
        n_checks++;
        if (mem_addr !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 0", mem_addr);
        end
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_vid_fetch();
        int n;
        mem_lat = 3;
        vid_addr = 18'h01234; vid_req = 1'b1;
        step();
        vid_req = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL vid_mem_req: got %b want 1", mem_req);
        end
        n_checks++;
        if (mem_addr !== 18'h01234) begin
            n_fail++; $display("FAIL vid_mem_addr: got %h want 01234", mem_addr);
        end
        wait_vid(20, n);
        n_checks++;
        if (n != 4) begin
            n_fail++; $display("FAIL vid_latency: got %0d want 4 cycles after mem_req", n);
        end
        n_checks++;
        if (vid_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL vid_data: got %h want deadbeef", vid_data);
        end
        step();
        n_checks++;
        if (vid_valid !== 1'b0) begin
            n_fail++; $display("FAIL vid_valid_pulse: got %b want 0", vid_valid);
        end
        repeat (2) step();
    endtask

    task automatic test_cpu_read();
        int n;
        txq.delete();
        cpu_addr = 18'h3FFFF; cpu_req = 1'b1;
        wait_cpu(20, n);
        n_checks++;
        if (n != 5) begin
            n_fail++; $display("FAIL cpu_latency: got %0d want 5", n);
        end
        n_checks++;
        if (cpu_data !== 32'h12345678) begin
            n_fail++; $display("FAIL cpu_data: got %h want 12345678", cpu_data);
        end
        step();
        n_checks++;
        if (cpu_ack !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL cpu_ack_block: got ack %b mem_req %b want 0 0", cpu_ack, mem_req);
        end
        cpu_req = 1'b0;
        repeat (3) step();
        n_checks++;
        if (txq.size() != 1) begin
            n_fail++; $display("FAIL cpu_txn_count: got %0d want 1", txq.size());
        end
    endtask

    task automatic test_vid_cpu_same();
        int n;
        logic [17:0] a0, a1;
        txq.delete();
        vid_addr = 18'h00ABC; vid_req = 1'b1;
        cpu_addr = 18'h00DEF; cpu_req = 1'b1;
        step();
        vid_req = 1'b0;
        wait_cpu(29, n);
        n = n + 1;
        cpu_req = 1'b0;
        n_checks++;
        if (n != 10) begin
            n_fail++; $display("FAIL same_cpu_latency: got %0d want 10", n);
        end
        repeat (3) step();
        a0 = (txq.size() > 0) ? txq[0] : 18'h0;
        a1 = (txq.size() > 1) ? txq[1] : 18'h0;
        n_checks++;
        if (txq.size() != 2 || a0 !== 18'h00ABC || a1 !== 18'h00DEF) begin
            n_fail++;
            $display("FAIL same_order: got n=%0d %h %h want 2 00abc 00def", txq.size(), a0, a1);
        end
        n_checks++;
        if (vid_data !== resp_data(18'h00ABC) || cpu_data !== resp_data(18'h00DEF)) begin
            n_fail++; $display("FAIL same_data: got vid %h cpu %h", vid_data, cpu_data);
        end
    endtask

    task automatic test_aging();
        int   gnt_t = -1;
        logic ack_seen = 1'b0;
        logic vid_after = 1'b0;
        logic prev = 1'b0;
        cpu_addr = 18'h02222; cpu_req = 1'b1;
        for (int t = 0; t < 60; t++) begin
            vid_req  = ((t % 4) == 0) && (t < 48);
            vid_addr = 18'h00100 + 18'(t);
            step();
            if (mem_req && !prev) begin
                if (mem_addr == 18'h02222 && gnt_t < 0) gnt_t = t + 1;
                else if (gnt_t >= 0 && mem_addr != 18'h02222) vid_after = 1'b1;
            end
            prev = mem_req;
            if (cpu_ack) begin
                ack_seen = 1'b1;
                cpu_req  = 1'b0;
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        n_checks++;
        if (gnt_t != 21) begin
            n_fail++; $display("FAIL aging_grant: got cycle %0d want 21", gnt_t);
        end
        n_checks++;
        if (ack_seen !== 1'b1 || vid_after !== 1'b1) begin
            n_fail++; $display("FAIL aging_resume: got ack %b vid_after %b want 1 1", ack_seen, vid_after);
        end
        repeat (15) step();
        n_checks++;
        if (vid_overrun !== 1'b1) begin
            n_fail++; $display("FAIL aging_overrun: got %b want 1", vid_overrun);
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        int n0;
        logic [17:0] a0, a1;
        txq.delete();
        n0 = nvv;
        cpu_addr = 18'h00555; cpu_req = 1'b1;
        step();
        vid_addr = 18'h00010; vid_req = 1'b1;
        step();
        n_checks++;
        if (vid_overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovr_first: got %b want 0", vid_overrun);
        end
        vid_addr = 18'h00020; ovr_clr = 1'b1;
        step();
        vid_req = 1'b0; ovr_clr = 1'b0;
        n_checks++;
        if (vid_overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovr_set_wins: got %b want 1", vid_overrun);
        end
        wait_cpu(20, n);
        cpu_req = 1'b0;
        wait_vid(20, n);
        n_checks++;
        if (n != 5) begin
            n_fail++; $display("FAIL ovr_vid_latency: got %0d want 5", n);
        end
        repeat (3) step();
        a0 = (txq.size() > 0) ? txq[0] : 18'h0;
        a1 = (txq.size() > 1) ? txq[1] : 18'h0;
        n_checks++;
        if (txq.size() != 2 || a0 !== 18'h00555 || a1 !== 18'h00020 || (nvv - n0) != 1) begin
            n_fail++;
            $display("FAIL ovr_txns: got n=%0d %h %h vv=%0d want 2 00555 00020 1", txq.size(), a0, a1, nvv - n0);
        end
        n_checks++;
        if (vid_data !== resp_data(18'h00020)) begin
            n_fail++; $display("FAIL ovr_data: got %h want %h", vid_data, resp_data(18'h00020));
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        n_checks++;
        if (vid_overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovr_clear: got %b want 0", vid_overrun);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int a0;
        mem_auto = 1'b0;
        step();
        n0 = nvv; a0 = nack;
        vid_addr = 18'h00777; vid_req = 1'b1;
        step();
        vid_req = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rmid_req: got %b want 1", mem_req);
        end
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, vid_valid, vid_overrun, cpu_ack} !== 4'b0000 || vid_data !== 32'h0 || mem_addr !== 18'h0) begin
            n_fail++;
            $display("FAIL rmid_async: got flags %b data %h addr %h want 0",
                     {mem_req, vid_valid, vid_overrun, cpu_ack}, vid_data, mem_addr);
        end
        step(); step();
        reset = 1'b0;
        step(); step();
        mem_ack = 1'b1; mem_dout = 32'hBAD0BAD0;
        step();
        mem_ack = 1'b0;
        repeat (3) step();
        n_checks++;
        if (nvv != n0 || nack != a0 || vid_data !== 32'h0 || cpu_data !== 32'h0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_stray_ack: got vv %0d ack %0d vdata %h cdata %h mreq %b want none/0",
                     nvv - n0, nack - a0, vid_data, cpu_data, mem_req);
        end
        mem_auto = 1'b1;
        step();
    endtask

    task automatic test_repeat_addr();
        int n;
        int sz;
        vid_addr = 18'h01234; vid_req = 1'b1;
        step();
        vid_req = 1'b0;
        wait_vid(20, n);
        repeat (2) step();
        sz = txq.size();
        vid_addr = 18'h01234; vid_req = 1'b1;
        step();
        vid_req = 1'b0;
`ifdef TILE_ARB_LASTADDR_CACHE_EN
        n_checks++;
        if (vid_valid !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL hit_fast: got valid %b mem_req %b want 1 0", vid_valid, mem_req);
        end
        n_checks++;
        if (vid_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL hit_data: got %h want deadbeef", vid_data);
        end
        repeat (3) step();
        n_checks++;
        if (txq.size() != sz) begin
            n_fail++; $display("FAIL hit_no_mem: got %0d txns want %0d", txq.size(), sz);
        end
        cpu_addr = 18'h00ABC; cpu_req = 1'b1;
        wait_cpu(20, n);
        cpu_req = 1'b0;
        step();
        vid_addr = 18'h00ABC; vid_req = 1'b1;
        step();
        vid_req = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || vid_valid !== 1'b0) begin
            n_fail++; $display("FAIL cpu_no_tag: got mem_req %b valid %b want 1 0", mem_req, vid_valid);
        end
        wait_vid(20, n);
`else
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 18'h01234 || vid_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_mem: got mem_req %b addr %h valid %b want 1 01234 0", mem_req, mem_addr, vid_valid);
        end
        wait_vid(20, n);
        n_checks++;
        if (n != 4 || txq.size() != sz + 1) begin
            n_fail++; $display("FAIL repeat_fetch: got lat %0d txns %0d want 4 %0d", n, txq.size(), sz + 1);
        end
`endif
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_vid_fetch();
        test_cpu_read();
        test_vid_cpu_same();
        test_aging();
        test_overrun();
        test_reset_mid();
        test_repeat_addr();
        n_checks++;
        if (addr_chg != 0) begin
            n_fail++; $display("FAIL addr_stable: got %0d changes while mem_req want 0", addr_chg);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
